// File: rtl/median3x3_filter_pkg.sv
// Shared constants for the 3x3 median filter.
//   DEFAULT_DATA_W : default pixel width in bits
//   MEDIAN_LATENCY : clocks from an accepted column to its dout_valid
//   BORDER_LOSS    : columns per line that never complete a full window
package median3x3_filter_pkg;
   localparam int DEFAULT_DATA_W = 8;
   localparam int MEDIAN_LATENCY = 3;
   localparam int BORDER_LOSS    = 2;
endpackage

// File: rtl/median3x3_filter_if.sv
// Column-in / pixel-out bundle of the 3x3 median filter.
//   vsync, in_valid, taps0x/1x/2x : column stream from the line buffer
//   dout, dout_valid, dout_eol    : filtered pixel stream to the frame writer
// master = line buffer / frame writer side, slave = the filter.
interface median3x3_filter_if
   import median3x3_filter_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic              vsync;
   logic              in_valid;
   logic [DATA_W-1:0] taps0x;
   logic [DATA_W-1:0] taps1x;
   logic [DATA_W-1:0] taps2x;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_eol;

   modport master (
      output vsync, in_valid, taps0x, taps1x, taps2x,
      input  dout, dout_valid, dout_eol
   );

   modport slave (
      input  vsync, in_valid, taps0x, taps1x, taps2x,
      output dout, dout_valid, dout_eol
   );
endinterface

// File: rtl/median3x3_filter_sort3.sv
// Combinational 3-input unsigned sorter.
//   a, b, c : inputs
//   max_val, mid_val, min_val : sorted outputs
module median3x3_filter_sort3
   import median3x3_filter_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
)(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] max_val,
   output logic [DATA_W-1:0] mid_val,
   output logic [DATA_W-1:0] min_val
);
   logic [DATA_W-1:0] hi_ab;
   logic [DATA_W-1:0] lo_ab;

   always_comb begin
      hi_ab   = (a > b) ? a : b;
      lo_ab   = (a > b) ? b : a;
      max_val = (hi_ab > c) ? hi_ab : c;
      min_val = (lo_ab < c) ? lo_ab : c;
      // c above the pair -> pair max is the median; below -> pair min
      if (c > hi_ab)
         mid_val = hi_ab;
      else if (c < lo_ab)
         mid_val = lo_ab;
      else
         mid_val = c;
   end
endmodule

// File: rtl/median3x3_filter.sv
// 3x3 median filter over a column stream of three vertically aligned pixels.
//   line_clk : pixel clock, rising edge
//   s_rst    : asynchronous active-high reset
//   bus      : slave side of median3x3_filter_if (columns in, medians out)
// A column with col_cnt >= 2 completes a window; the window then passes
// row sort -> column max/mid/min -> final mid, giving dout three clocks
// after the column edge. One output per complete window, none on borders.
module median3x3_filter
   import median3x3_filter_pkg::*;
#(
   parameter int IMAGE_WIDTH = 480,
   parameter int DATA_W      = DEFAULT_DATA_W
)(
   input  logic              line_clk,
   input  logic              s_rst,
   median3x3_filter_if.slave bus
);
   localparam int               CNT_W     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMAGE_WIDTH - 1);
   localparam logic [CNT_W-1:0] FIRST_WIN = CNT_W'(BORDER_LOSS);

   logic [DATA_W-1:0] taps [3];
   logic [DATA_W-1:0] win_p0 [3][3];   // [row][col], col 0 newest
   logic [CNT_W-1:0]  col_cnt;
   logic              accept;
   logic              vld_p0, eol_p0;

   logic [DATA_W-1:0] row_max [3], row_mid [3], row_min [3];
   logic [DATA_W-1:0] max_p1 [3], mid_p1 [3], min_p1 [3];
   logic              vld_p1, eol_p1;

   logic [DATA_W-1:0] lo_max, mid_mid, hi_min;
   logic [DATA_W-1:0] unused_s2 [6];
   logic [DATA_W-1:0] unused_s3 [2];
   logic [DATA_W-1:0] lo_max_p2, mid_mid_p2, hi_min_p2;
   logic              vld_p2, eol_p2;
   logic [DATA_W-1:0] median;

   always_comb begin
      taps[0] = bus.taps0x;
      taps[1] = bus.taps1x;
      taps[2] = bus.taps2x;
      accept  = bus.in_valid && !bus.vsync;
   end

   // ---- p0: window and column counter ----
   // Any idle cycle clears col_cnt, which covers the in_valid falling edge
   // and keeps windows from straddling two lines.
   always_ff @(posedge line_clk or posedge s_rst) begin
      if (s_rst) begin
         col_cnt <= '0;
         vld_p0  <= 1'b0;
         eol_p0  <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_p0[r][c] <= '0;
      end else begin
         vld_p0 <= accept && (col_cnt >= FIRST_WIN);
         eol_p0 <= accept && (col_cnt == LAST_COL);
         if (bus.vsync) begin
            col_cnt <= '0;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  win_p0[r][c] <= '0;
         end else if (bus.in_valid) begin
            col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + CNT_W'(1);
            for (int r = 0; r < 3; r++) begin
               win_p0[r][2] <= win_p0[r][1];
               win_p0[r][1] <= win_p0[r][0];
               win_p0[r][0] <= taps[r];
            end
         end else begin
            col_cnt <= '0;
         end
      end
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      median3x3_filter_sort3 #(.DATA_W(DATA_W)) u_row_sort (
         .a(win_p0[r][0]), .b(win_p0[r][1]), .c(win_p0[r][2]),
         .max_val(row_max[r]), .mid_val(row_mid[r]), .min_val(row_min[r])
      );
   end

   // ---- p1: each row sorted ----
   always_ff @(posedge line_clk or posedge s_rst) begin
      if (s_rst) begin
         vld_p1 <= 1'b0;
         eol_p1 <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            max_p1[r] <= '0;
            mid_p1[r] <= '0;
            min_p1[r] <= '0;
         end
      end else begin
         vld_p1 <= vld_p0;
         eol_p1 <= eol_p0;
         for (int r = 0; r < 3; r++) begin
            max_p1[r] <= row_max[r];
            mid_p1[r] <= row_mid[r];
            min_p1[r] <= row_min[r];
         end
      end
   end

   median3x3_filter_sort3 #(.DATA_W(DATA_W)) u_mins (
      .a(min_p1[0]), .b(min_p1[1]), .c(min_p1[2]),
      .max_val(lo_max), .mid_val(unused_s2[0]), .min_val(unused_s2[1])
   );
   median3x3_filter_sort3 #(.DATA_W(DATA_W)) u_mids (
      .a(mid_p1[0]), .b(mid_p1[1]), .c(mid_p1[2]),
      .max_val(unused_s2[2]), .mid_val(mid_mid), .min_val(unused_s2[3])
   );
   median3x3_filter_sort3 #(.DATA_W(DATA_W)) u_maxs (
      .a(max_p1[0]), .b(max_p1[1]), .c(max_p1[2]),
      .max_val(unused_s2[4]), .mid_val(unused_s2[5]), .min_val(hi_min)
   );

   // ---- p2: max of mins, mid of mids, min of maxes ----
   always_ff @(posedge line_clk or posedge s_rst) begin
      if (s_rst) begin
         vld_p2     <= 1'b0;
         eol_p2     <= 1'b0;
         lo_max_p2  <= '0;
         mid_mid_p2 <= '0;
         hi_min_p2  <= '0;
      end else begin
         vld_p2     <= vld_p1;
         eol_p2     <= eol_p1;
         lo_max_p2  <= lo_max;
         mid_mid_p2 <= mid_mid;
         hi_min_p2  <= hi_min;
      end
   end

   median3x3_filter_sort3 #(.DATA_W(DATA_W)) u_final (
      .a(lo_max_p2), .b(mid_mid_p2), .c(hi_min_p2),
      .max_val(unused_s3[0]), .mid_val(median), .min_val(unused_s3[1])
   );

   // ---- output: dout holds its value between valid pixels ----
   always_ff @(posedge line_clk or posedge s_rst) begin
      if (s_rst) begin
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_eol   <= 1'b0;
      end else begin
         bus.dout_valid <= vld_p2;
         bus.dout_eol   <= vld_p2 && eol_p2;
         if (vld_p2)
            bus.dout <= median;
      end
   end
endmodule

// File: doc/median3x3_filter.md
Name: median3x3_filter

Overview:
- Downstream consumer of the 3-row line buffer; takes three vertically aligned pixels per cycle (top/mid/bottom rows) and produces the 3x3 median.
- Builds a sliding 3x3 window from the column stream.
- Runs a 3-stage sorting-network pipeline: row sort, column max/mid/min, final median.
- Emits one filtered pixel per valid window plus an end-of-line marker for the frame writer.

Parameters:
IMAGE_WIDTH, 480, pixels per line; sets column counter wrap.
DATA_W, 8, pixel width in bits.

Ports:
line_clk  in  1  pixel clock; all logic rising-edge.
s_rst  in  1  asynchronous, active-high reset.
vsync  in  1  frame sync; high clears window and counters synchronously.
in_valid  in  1  column valid; driven by the line buffer done output.
taps0x  in  DATA_W  top row pixel, oldest line.
taps1x  in  DATA_W  middle row pixel.
taps2x  in  DATA_W  bottom row pixel, current line.
dout  out  DATA_W  median of the 3x3 window.
dout_valid  out  1  dout qualifier.
dout_eol  out  1  high with the last valid output of a line.

Behaviour:
- Reset (async, s_rst=1):
  - Window regs, pipeline regs and col_cnt clear to 0.
  - dout=0, dout_valid=0, dout_eol=0.
  - Reset mid-line discards all in-flight pixels; no output until 3 new columns arrive.
- Window:
  - 3 rows x 3 columns of regs; shift on in_valid=1 only.
  - Column 0 <= taps, column 1 <= column 0, column 2 <= column 1.
  - With in_valid=0 the window holds.
- col_cnt (ceil(log2(IMAGE_WIDTH)) bits):
  - Counts accepted columns in the current line.
  - Increments on in_valid=1; wraps to 0 after IMAGE_WIDTH-1, so back-to-back lines with no gap are supported.
  - Clears to 0 when in_valid falls (first cycle in_valid=0 after a 1) or when vsync=1.
  - vsync has priority over in_valid.
- Window valid when an accepted column has col_cnt>=2 (pre-increment value). Windows never straddle two lines.
- Pipeline:
  - Stage 1: sort each window row into max/mid/min.
  - Stage 2: take max of the three row-mins, mid of the three row-mids, min of the three row-maxes.
  - Stage 3: take mid of those three values; register to dout.
- Valid/eol tags travel alongside the data, one register per stage.
- Latency: column accepted at edge N, window registered at N, dout_valid at edge N+3.
- Throughput: 1 pixel/clk.
- Output count: IMAGE_WIDTH-2 outputs per line. Border columns produce no output; the downstream block pads borders.
- dout_eol asserts with the output whose window's newest column had col_cnt=IMAGE_WIDTH-1.
- Comparisons are unsigned, DATA_W wide; no arithmetic, so no overflow.
- Equal values: any consistent ordering is acceptable, since the median value is unaffected.
- When dout_valid=0, dout holds its last value; the bench checks dout only when dout_valid=1.
- vsync mid-pipeline:
  - Clears the window and col_cnt.
  - Already-issued pipeline stages drain normally; up to 3 trailing outputs are allowed.
- No backpressure input; the consumer must accept every dout_valid cycle.

Decomposition:
- Shared package holds:
  - DATA_W default.
  - MEDIAN_LATENCY=3.
  - A constant for the border loss per line (2).
- Natural sub-module: sort3, a combinational 3-input sorter with outputs max/mid/min.
  - Instantiated 3 times in stage 1, 3 times in stage 2, once in stage 3.
  - Unused outputs are left to synthesis to trim.

Test Plan:
- Flat image, all taps=100, IMAGE_WIDTH=8, one line of 8 valid columns -> exactly 6 outputs, all dout=100, dout_eol only on the 6th; first dout_valid 3 clocks after the 3rd column edge.
- Impulse: field of 10 with a single 255 at mid row, column 4 -> every output =10 (salt removed).
- Ascending window: columns {1,2,3},{4,5,6},{7,8,9} (top,mid,bot) -> first output =5; next column {10,11,12} -> output =8.
- Line gap: 8 columns, in_valid low 4 cycles, 8 more -> 6+6 outputs; no output uses columns from both lines.
- Back-to-back: in_valid high for 16 cycles with IMAGE_WIDTH=8 -> 12 outputs, eol on the 6th and 12th, wrap at col_cnt=7.
- Reset mid-line: s_rst pulsed after 5 columns -> outputs drop to 0/invalid immediately; the next line produces 6 correct outputs.
